// File: rtl/osd_cmd_seq_if.sv
// Host-side write stream into the OSD command sequencer.
// The master drives words; the slave (sequencer) returns ready.
interface osd_cmd_seq_if;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        wr_ready;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/osd_cmd_seq.sv
// Buffers host OSD command packets in a FIFO and replays them onto the OSD bus
// with packet framing (io_osd), per-word strobe timing and an inter-packet gap.
module osd_cmd_seq #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned HOLD_LEN   = 2,
  parameter int unsigned GAP_LEN    = 4
) (
  input  logic                clk_sys,
  input  logic                reset,
  osd_cmd_seq_if.slave        wr,
  input  logic                abort,
  output logic                io_osd,
  output logic                io_strobe,
  output logic [15:0]         io_din,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                pkt_done
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned MaxSg  = (STROBE_LEN > HOLD_LEN) ? STROBE_LEN : HOLD_LEN;
  localparam int unsigned MaxLen = (MaxSg > GAP_LEN) ? MaxSg : GAP_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StWait, StGap} state_e;

  logic [16:0]           r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level, r_pkt_count;
  state_e                r_state, w_state_next;
  logic [CntW-1:0]       r_cnt, w_cnt_next, w_len_m1;
  logic                  r_last, r_osd, r_strobe, r_pkt_done;
  logic [15:0]           r_din;
  logic                  w_full, w_empty, w_push, w_pop, w_cnt_end, w_done;
  logic [16:0]           w_head;

  assign w_full      = (r_level == (DEPTH_LOG2 + 1)'(Depth));
  assign w_empty     = (r_level == '0);
  assign wr.wr_ready = !w_full && !abort && !reset;
  assign w_push      = wr.wr_valid && wr.wr_ready;
  // SETUP is only entered with a non-empty FIFO, so its pop never underflows.
  assign w_pop       = (r_state == StSetup) && !abort;
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr.wr_last, wr.wr_data};
  end

  always_ff @(posedge clk_sys) begin
    if (reset || abort) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if ((w_push && wr.wr_last) && !(w_pop && w_head[16]))      r_pkt_count <= r_pkt_count + 1'b1;
      else if (!(w_push && wr.wr_last) && (w_pop && w_head[16])) r_pkt_count <= r_pkt_count - 1'b1;
    end
  end

  always_comb begin
    w_len_m1 = '0;
    case (r_state)
      StStrobe: w_len_m1 = CntW'(STROBE_LEN - 1);
      StHold:   w_len_m1 = CntW'(HOLD_LEN - 1);
      StGap:    w_len_m1 = CntW'(GAP_LEN - 1);
      default:  w_len_m1 = '0;
    endcase
  end

  assign w_cnt_end = (r_cnt == w_len_m1);

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle:   if (r_pkt_count != '0 || w_full) w_state_next = StSetup;
      StSetup:  w_state_next = StStrobe;
      StStrobe: if (w_cnt_end) w_state_next = StHold;
      StHold: begin
        if (w_cnt_end) begin
          if (r_last) begin
            w_state_next = StGap;
            w_done       = 1'b1;
          end else if (!w_empty) begin
            w_state_next = StSetup;
          end else begin
            w_state_next = StWait;
          end
        end
      end
      StWait:   if (!w_empty) w_state_next = StSetup;
      StGap:    if (w_cnt_end) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    if (abort) begin
      w_state_next = StGap;
      w_done       = 1'b0;
    end
    w_cnt_next = (abort || w_state_next != r_state) ? '0 : r_cnt + 1'b1;
  end

  // Bus outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_osd      <= 1'b0;
      r_strobe   <= 1'b0;
      r_din      <= '0;
      r_last     <= 1'b0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pkt_done <= w_done;
      if (abort) begin
        r_osd    <= 1'b0;
        r_strobe <= 1'b0;
      end else begin
        r_osd    <= (r_state == StSetup) || (r_state == StStrobe) ||
                    (r_state == StHold)  || (r_state == StWait);
        r_strobe <= (r_state == StStrobe);
      end
      if (w_pop) begin
        r_din  <= w_head[15:0];
        r_last <= w_head[16];
      end
    end
  end

  assign io_osd     = r_osd;
  assign io_strobe  = r_strobe;
  assign io_din     = r_din;
  assign busy       = (r_state != StIdle);
  assign fifo_level = r_level;
  assign pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_osd_cmd_seq.sv
// Directed bench for osd_cmd_seq: single/multi-word packets, back-to-back,
// full-FIFO streaming with underrun, and abort.
module tb_osd_cmd_seq;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        abort;
  logic        io_osd, io_strobe, busy, pkt_done;
  logic [15:0] io_din;
  logic [5:0]  fifo_level;

  osd_cmd_seq_if wr_if ();

  osd_cmd_seq #(
    .DEPTH_LOG2 (5),
    .STROBE_LEN (2),
    .HOLD_LEN   (2),
    .GAP_LEN    (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .wr         (wr_if),
    .abort      (abort),
    .io_osd     (io_osd),
    .io_strobe  (io_strobe),
    .io_din     (io_din),
    .busy       (busy),
    .fifo_level (fifo_level),
    .pkt_done   (pkt_done)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor sampled on the falling edge.
  int          cyc = 0;
  logic [15:0] q_din [$];
  int          q_t [$];
  int          frames = 0, done_cnt = 0, din_viol = 0, width_viol = 0;
  int          low_run = 0, min_gap = 999, s_run = 0;
  logic        p_strobe = 1'b0, p_osd = 1'b0;
  logic [15:0] p_din = '0;

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (io_strobe === 1'b1 && !p_strobe) begin
      q_din.push_back(io_din);
      q_t.push_back(cyc);
    end
    if (io_strobe === 1'b1 && p_strobe && io_din != p_din) din_viol++;
    if (io_strobe === 1'b1) s_run++;
    else if (p_strobe) begin
      if (s_run != 2) width_viol++;
      s_run = 0;
    end
    if (io_osd === 1'b1 && !p_osd) begin
      frames++;
      if (low_run < min_gap) min_gap = low_run;
    end
    if (io_osd === 1'b1) low_run = 0;
    else low_run++;
    if (pkt_done === 1'b1) done_cnt++;
    p_strobe = (io_strobe === 1'b1);
    p_osd    = (io_osd === 1'b1);
    p_din    = io_din;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_last  = l;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    check_val(tag, done_cnt, target);
  endtask

  int waits, bad, osd_rise0;

  initial begin
    reset          = 1'b1;
    abort          = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_last  = 1'b0;
    repeat (3) step();
    check_val("rst_wr_ready", wr_if.wr_ready, 0);
    check_val("rst_osd", io_osd, 0);
    check_val("rst_strobe", io_strobe, 0);
    check_val("rst_din", io_din, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_done", pkt_done, 0);
    reset = 1'b0;
    step();
    check_val("post_rst_ready", wr_if.wr_ready, 1);

    // 1: single-word packet, cycle-exact latency
    push(16'h0041, 1'b1);                         // accepted at edge N
    check_val("t1_level", fifo_level, 1);
    step(); check_val("t1_osd_n1", io_osd, 0);
    step(); check_val("t1_osd_n2", io_osd, 1); check_val("t1_din", io_din, 16'h0041);
    check_val("t1_stb_n2", io_strobe, 0);
    step(); check_val("t1_stb_n3", io_strobe, 1);
    step(); check_val("t1_stb_n4", io_strobe, 1);
    step(); check_val("t1_stb_n5", io_strobe, 0); check_val("t1_done_n5", pkt_done, 0);
    step(); check_val("t1_done_n6", pkt_done, 1); check_val("t1_osd_n6", io_osd, 1);
    step(); check_val("t1_osd_n7", io_osd, 0); check_val("t1_done_n7", pkt_done, 0);
    step(); step(); check_val("t1_busy_n9", busy, 1);
    step(); check_val("t1_busy_n10", busy, 0);
    check_val("t1_ndone", done_cnt, 1);
    check_val("t1_nstb", q_din.size(), 1);

    // 2: three-word packet in a single frame, 5 cycles per word
    q_din.delete(); q_t.delete();
    push(16'h0020, 1'b0); push(16'h00AA, 1'b0); push(16'h0055, 1'b1);
    wait_done("t2_done", 2, 100);
    check_val("t2_nwords", q_din.size(), 3);
    if (q_din.size() == 3) begin
      check_val("t2_w0", q_din[0], 16'h0020);
      check_val("t2_w1", q_din[1], 16'h00AA);
      check_val("t2_w2", q_din[2], 16'h0055);
      check_val("t2_sp01", q_t[1] - q_t[0], 5);
      check_val("t2_sp12", q_t[2] - q_t[1], 5);
    end
    check_val("t2_frames", frames, 2);

    // 3: back-to-back single-word packets
    repeat (8) step();
    q_din.delete();
    push(16'h0011, 1'b1); push(16'h0022, 1'b1);
    check_val("t3_pc2", dut.r_pkt_count, 2);
    step(); check_val("t3_pc1", dut.r_pkt_count, 1);
    wait_done("t3_done", 4, 100);
    check_val("t3_pc0", dut.r_pkt_count, 0);
    check_val("t3_frames", frames, 4);
    check_val("t3_words", {q_din[0], q_din[1]}, {16'h0011, 16'h0022});

    // 4: full FIFO triggers streaming; 33rd word waits for the first pop
    repeat (8) step();
    q_din.delete();
    for (int i = 0; i < 32; i++) push(16'h0100 + 16'(i), 1'b0);
    check_val("t4_level32", fifo_level, 32);
    check_val("t4_ready_full", wr_if.wr_ready, 0);
    wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'h0120; wr_if.wr_last = 1'b0;
    waits = 0;
    while (!wr_if.wr_ready && waits < 50) begin step(); waits++; end
    step();
    wr_if.wr_valid = 1'b0;
    check_val("t4_full_wait", waits, 2);

    // 5: drain into underrun (WAIT), then resume with the last word
    for (int i = 0; i < 400 && fifo_level != 0; i++) step();
    repeat (6) step();
    check_val("t5_nwords_wait", q_din.size(), 33);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (io_osd !== 1'b1 || io_strobe !== 1'b0 || io_din !== 16'h0120 || busy !== 1'b1) bad++;
      step();
    end
    check_val("t5_wait_hold", bad, 0);
    push(16'h0BEE, 1'b1);
    wait_done("t5_done", 5, 100);
    check_val("t5_nwords", q_din.size(), 34);
    if (q_din.size() == 34) begin
      check_val("t5_first", q_din[0], 16'h0100);
      check_val("t5_w31", q_din[31], 16'h011F);
      check_val("t5_w32", q_din[32], 16'h0120);
      check_val("t5_last", q_din[33], 16'h0BEE);
    end
    check_val("t5_frames", frames, 5);

    // 6: abort during word 2 of a 4-word packet with a write pending
    repeat (8) step();
    q_din.delete();
    push(16'h0031, 1'b0); push(16'h0032, 1'b0); push(16'h0033, 1'b0); push(16'h0034, 1'b1);
    for (int i = 0; i < 60 && q_din.size() < 2; i++) step();
    check_val("t6_stb_at_abort", io_strobe, 1);
    abort = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'hDEAD; wr_if.wr_last = 1'b1;
    #1;
    check_val("t6_ready_abort", wr_if.wr_ready, 0);
    step();
    abort = 1'b0; wr_if.wr_valid = 1'b0;
    check_val("t6_osd", io_osd, 0);
    check_val("t6_stb", io_strobe, 0);
    check_val("t6_level", fifo_level, 0);
    check_val("t6_pc", dut.r_pkt_count, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (io_osd !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    check_val("t6_gap_low", bad, 0);
    check_val("t6_idle", busy, 0);
    check_val("t6_no_done", done_cnt, 5);
    check_val("t6_words_before", q_din.size(), 2);
    osd_rise0 = frames;
    push(16'h0077, 1'b1);
    wait_done("t6_new_done", 6, 100);
    check_val("t6_new_frame", frames, osd_rise0 + 1);
    check_val("t6_new_word", q_din.size() == 3 ? q_din[2] : 16'h0, 16'h0077);

    repeat (10) step();
    check_val("din_stable", din_viol, 0);
    check_val("strobe_width", width_viol, 0);
    check_val("min_gap_ok", min_gap >= 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
